// File: rtl/scroll_matrix_driver.sv
// scroll_matrix_driver
//
// Display stage for the character-column generator. Every column byte that
// arrives with col_valid is pushed into an 8-column scroll register (newest
// at the right edge, column 7), and the resulting image is row-multiplexed
// onto an 8x8 LED matrix.
//
// Parameters:
//   PRESCALE_W  - row dwell is 2^PRESCALE_W clocks; a frame is 8 rows.
//
// Ports:
//   clk         - single clock, rising edge
//   rst         - synchronous, active-high reset
//   col_in      - column byte, bit r = LED in row r (bit 0 top)
//   col_valid   - col_in holds a new column this clock
//   row_out     - one-hot row enable, active-high
//   col_out     - column drive for the active row, bit c = column c (0 left)
//   frame_start - one-cycle pulse on the first clock of row 0 dwell
//
// Optional feature:
//   SCROLL_MATRIX_TEAR_FREE_EN - when defined, the scan reads a display
//   buffer that is reloaded from the scroll register only at frame
//   boundaries, so the image never changes mid-frame.

module scroll_matrix_driver #(
  parameter int PRESCALE_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] col_in,
  input  logic       col_valid,
  output logic [7:0] row_out,
  output logic [7:0] col_out,
  output logic       frame_start
);

  logic [7:0]            sr [8];
  logic [PRESCALE_W-1:0] pre;
  logic [2:0]            row;
  logic                  pre_wrap;
  logic                  frame_boundary;
  logic [7:0]            scan [8];
  logic [7:0]            col_bits;

  assign pre_wrap       = (pre == {PRESCALE_W{1'b1}});
  assign frame_boundary = pre_wrap && (row == 3'd7);

  // Prescaler and row counter: the row advances on the clock where the
  // prescaler wraps, giving exactly 2^PRESCALE_W clocks per row.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      row <= 3'd0;
    end else begin
      pre <= pre + 1'b1;
      if (pre_wrap)
        row <= row + 3'd1;
    end
  end

  // Scroll register: each accepted column enters at column 7 and everything
  // else moves one place left; the oldest column falls off column 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 8; c++)
        sr[c] <= 8'h00;
    end else if (col_valid) begin
      for (int c = 0; c < 7; c++)
        sr[c] <= sr[c+1];
      sr[7] <= col_in;
    end
  end

`ifdef SCROLL_MATRIX_TEAR_FREE_EN
  logic [7:0] db [8];

  // Display buffer snapshots the pre-edge scroll register at the frame
  // boundary; a column accepted on that same clock waits for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 8; c++)
        db[c] <= 8'h00;
    end else if (frame_boundary) begin
      for (int c = 0; c < 8; c++)
        db[c] <= sr[c];
    end
  end

  always_comb begin
    for (int c = 0; c < 8; c++)
      scan[c] = db[c];
  end
`else
  always_comb begin
    for (int c = 0; c < 8; c++)
      scan[c] = sr[c];
  end

  // Without the display buffer the frame boundary has no consumer.
  logic unused_boundary;
  assign unused_boundary = frame_boundary;
`endif

  // Pick the current row's bit out of every column of the scan source.
  always_comb begin
    col_bits = 8'h00;
    for (int c = 0; c < 8; c++)
      col_bits[c] = scan[c][row];
  end

  // Row enable and column drive are registered together so a row change
  // lands on both on the same edge and rows never overlap.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_out     <= 8'h00;
      col_out     <= 8'h00;
      frame_start <= 1'b0;
    end else begin
      row_out     <= 8'd1 << row;
      col_out     <= col_bits;
      frame_start <= (row == 3'd0) && (pre == '0);
    end
  end

endmodule

// File: tb/tb_scroll_matrix_driver.sv
// tb_scroll_matrix_driver
//
// Bench for scroll_matrix_driver with PRESCALE_W=2 (4 clocks per row,
// 32 clocks per frame). A reference model derives the scan position from
// the number of clocks since reset and keeps the image as a plain array of
// columns; every cycle's outputs are compared against it, and the directed
// phases add fixed-pattern checks. Honours SCROLL_MATRIX_TEAR_FREE_EN.

module tb_scroll_matrix_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] col_in;
  logic       col_valid;
  logic [7:0] row_out;
  logic [7:0] col_out;
  logic       frame_start;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int         clocks_since_reset;
  logic [7:0] image   [8];
  logic [7:0] shown   [8];
  logic [7:0] exp_row;
  logic [7:0] exp_col;
  logic       exp_fs;

  scroll_matrix_driver #(.PRESCALE_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .col_in      (col_in),
    .col_valid   (col_valid),
    .row_out     (row_out),
    .col_out     (col_out),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expectation.
  task automatic check_output(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h at t=%0t", tag, observed,
             expected, $time);
    end
  endtask

  // Expected outputs for the edge about to happen, then advance the model.
  task automatic model_edge(input logic r, input logic v, input logic [7:0] d);
    int cur_row;
    logic [7:0] src [8];
    if (r) begin
      exp_row = 8'h00;
      exp_col = 8'h00;
      exp_fs  = 1'b0;
      clocks_since_reset = 0;
      for (int c = 0; c < 8; c++) begin
        image[c] = 8'h00;
        shown[c] = 8'h00;
      end
    end else begin
      cur_row = (clocks_since_reset / 4) % 8;
      for (int c = 0; c < 8; c++) begin
`ifdef SCROLL_MATRIX_TEAR_FREE_EN
        src[c] = shown[c];
`else
        src[c] = image[c];
`endif
      end
      exp_row = 8'(1 << cur_row);
      exp_fs  = ((clocks_since_reset % 32) == 0);
      exp_col = 8'h00;
      for (int c = 0; c < 8; c++)
        exp_col[c] = src[c][cur_row];
      if ((clocks_since_reset % 32) == 31)
        for (int c = 0; c < 8; c++)
          shown[c] = image[c];
      if (v) begin
        for (int c = 0; c < 7; c++)
          image[c] = image[c+1];
        image[7] = d;
      end
      clocks_since_reset++;
    end
  endtask

  // Drive one clock of inputs, then check all outputs against the model.
  task automatic apply_stimulus(input logic r, input logic v,
                                input logic [7:0] d);
    rst       = r;
    col_valid = v;
    col_in    = d;
    @(posedge clk);
    model_edge(r, v, d);
    #1;
    check_output("row_out", row_out, exp_row);
    check_output("col_out", col_out, exp_col);
    check_output("frame_start", {7'd0, frame_start}, {7'd0, exp_fs});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      apply_stimulus(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    rst = 1'b1; col_valid = 1'b0; col_in = 8'h00;
    clocks_since_reset = 0;
    for (int c = 0; c < 8; c++) begin
      image[c] = 8'h00;
      shown[c] = 8'h00;
    end

    // Reset held for three clocks
    for (int i = 0; i < 3; i++)
      apply_stimulus(1'b1, 1'b0, 8'h00);
    check_output("reset_row", row_out, 8'h00);
    check_output("reset_col", col_out, 8'h00);

    // First cycle after release
    apply_stimulus(1'b0, 1'b0, 8'h00);
    check_output("first_row", row_out, 8'h01);
    check_output("first_fs", {7'd0, frame_start}, 8'h01);

    // Empty row scan over more than two frames
    idle(70);

    // Single column 0x7F lights column 7 in rows 0..6
    apply_stimulus(1'b0, 1'b1, 8'h7F);
    idle(64);
    for (int i = 0; i < 32; i++) begin
      apply_stimulus(1'b0, 1'b0, 8'h00);
      check_output("single_col", col_out, (row_out == 8'h80) ? 8'h00 : 8'h80);
    end

    // Diagonal from eight consecutive one-hot columns
    apply_stimulus(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++)
      apply_stimulus(1'b0, 1'b1, 8'(1 << i));
    idle(64);
    for (int i = 0; i < 32; i++) begin
      apply_stimulus(1'b0, 1'b0, 8'h00);
      check_output("diagonal", col_out, row_out);
    end

    // Ninth column pushes the first one out
    apply_stimulus(1'b0, 1'b1, 8'hFF);
    idle(64);
    for (int i = 0; i < 32; i++) begin
      apply_stimulus(1'b0, 1'b0, 8'h00);
      check_output("ninth_col", col_out, (row_out >> 1) | 8'h80);
    end

    // Column arriving exactly on the frame-boundary clock
    apply_stimulus(1'b1, 1'b0, 8'h00);
    while ((clocks_since_reset % 32) != 31)
      apply_stimulus(1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b1, 8'hFF);
`ifdef SCROLL_MATRIX_TEAR_FREE_EN
    for (int i = 0; i < 32; i++) begin
      apply_stimulus(1'b0, 1'b0, 8'h00);
      check_output("tear_hold", col_out, 8'h00);
    end
`endif
    for (int i = 0; i < 32; i++) begin
      apply_stimulus(1'b0, 1'b0, 8'h00);
      check_output("boundary_col", col_out, 8'h80);
    end

    // Mid-frame reset during row 4
    while (((clocks_since_reset / 4) % 8) != 4)
      apply_stimulus(1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b1, 1'b0, 8'h00);
    check_output("midrst_row", row_out, 8'h00);
    check_output("midrst_col", col_out, 8'h00);
    apply_stimulus(1'b0, 1'b0, 8'h00);
    check_output("midrst_next_row", row_out, 8'h01);
    check_output("midrst_next_fs", {7'd0, frame_start}, 8'h01);
    idle(40);
    check_output("midrst_empty", col_out, 8'h00);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++)
      apply_stimulus($urandom_range(0, 149) == 0, $urandom_range(0, 3) == 0,
                     8'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
